// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: ALU function codes,
// opcode/funct values, FSM state encodings and datapath mux selects.
package mips_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned ALU_W   = 6;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned SEL_W   = 2;

   localparam logic [ALU_W-1:0] ALU_ADD = 6'b000000;
   localparam logic [ALU_W-1:0] ALU_SUB = 6'b000001;
   localparam logic [ALU_W-1:0] ALU_AND = 6'b011000;
   localparam logic [ALU_W-1:0] ALU_OR  = 6'b011110;
   localparam logic [ALU_W-1:0] ALU_XOR = 6'b010110;
   localparam logic [ALU_W-1:0] ALU_NOR = 6'b010001;
   localparam logic [ALU_W-1:0] ALU_A   = 6'b011010;
   localparam logic [ALU_W-1:0] ALU_SLL = 6'b100000;
   localparam logic [ALU_W-1:0] ALU_SRL = 6'b100001;
   localparam logic [ALU_W-1:0] ALU_SRA = 6'b100011;
   localparam logic [ALU_W-1:0] ALU_EQ  = 6'b110011;
   localparam logic [ALU_W-1:0] ALU_NEQ = 6'b110001;
   localparam logic [ALU_W-1:0] ALU_LT  = 6'b110101;
   localparam logic [ALU_W-1:0] ALU_LEZ = 6'b111101;
   localparam logic [ALU_W-1:0] ALU_GTZ = 6'b111111;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
   localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FN_W-1:0] FN_SLL  = 6'h00;
   localparam logic [FN_W-1:0] FN_SRL  = 6'h02;
   localparam logic [FN_W-1:0] FN_SRA  = 6'h03;
   localparam logic [FN_W-1:0] FN_JR   = 6'h08;
   localparam logic [FN_W-1:0] FN_JALR = 6'h09;
   localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
   localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
   localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
   localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
   localparam logic [FN_W-1:0] FN_AND  = 6'h24;
   localparam logic [FN_W-1:0] FN_OR   = 6'h25;
   localparam logic [FN_W-1:0] FN_XOR  = 6'h26;
   localparam logic [FN_W-1:0] FN_NOR  = 6'h27;
   localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;
   localparam logic [FN_W-1:0] FN_SLTU = 6'h2B;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_MEM   = 4'd7,
      S_WB_ALU   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   localparam logic [SEL_W-1:0] SRCA_PC      = 2'd0;
   localparam logic [SEL_W-1:0] SRCA_RS      = 2'd1;
   localparam logic [SEL_W-1:0] SRCA_SHAMT   = 2'd2;
   localparam logic [SEL_W-1:0] SRCB_RT      = 2'd0;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'd3;
   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [SEL_W-1:0] PCSRC_EXC    = 2'd3;
   localparam logic [SEL_W-1:0] REGDST_RT    = 2'd0;
   localparam logic [SEL_W-1:0] REGDST_RD    = 2'd1;
   localparam logic [SEL_W-1:0] REGDST_RA    = 2'd2;
   localparam logic [SEL_W-1:0] M2R_ALU      = 2'd0;
   localparam logic [SEL_W-1:0] M2R_MDR      = 2'd1;
   localparam logic [SEL_W-1:0] M2R_PC       = 2'd2;

   function automatic logic is_shift(input logic [FN_W-1:0] fn);
      return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
   endfunction

endpackage

// File: rtl/mc_alu_fun_dec.sv
// Combinational OpCode/Funct decoder: ALU function, signedness and an
// illegal flag for unknown opcodes or R-type functs.
module mc_alu_fun_dec
   import mips_ctrl_pkg::*;
(
   input  logic [OP_W-1:0]  i_opcode,
   input  logic [FN_W-1:0]  i_funct,
   output logic [ALU_W-1:0] o_alu_fun,
   output logic             o_sign,
   output logic             o_illegal
);

   always_comb begin
      o_alu_fun = ALU_ADD;
      o_sign    = 1'b1;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD:  o_alu_fun = ALU_ADD;
               FN_ADDU: begin o_alu_fun = ALU_ADD; o_sign = 1'b0; end
               FN_SUB:  o_alu_fun = ALU_SUB;
               FN_SUBU: begin o_alu_fun = ALU_SUB; o_sign = 1'b0; end
               FN_AND:  o_alu_fun = ALU_AND;
               FN_OR:   o_alu_fun = ALU_OR;
               FN_XOR:  o_alu_fun = ALU_XOR;
               FN_NOR:  o_alu_fun = ALU_NOR;
               FN_SLT:  o_alu_fun = ALU_LT;
               FN_SLTU: begin o_alu_fun = ALU_LT; o_sign = 1'b0; end
               FN_SLL:  o_alu_fun = ALU_SLL;
               FN_SRL:  o_alu_fun = ALU_SRL;
               FN_SRA:  o_alu_fun = ALU_SRA;
               FN_JR, FN_JALR: o_alu_fun = ALU_A;
               default: o_illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU: o_alu_fun = ALU_ADD;
         OP_SLTI:  o_alu_fun = ALU_LT;
         OP_SLTIU: begin o_alu_fun = ALU_LT;  o_sign = 1'b0; end
         OP_ANDI:  begin o_alu_fun = ALU_AND; o_sign = 1'b0; end
         OP_ORI:   begin o_alu_fun = ALU_OR;  o_sign = 1'b0; end
         OP_XORI:  begin o_alu_fun = ALU_XOR; o_sign = 1'b0; end
         // lui: immediate arrives upper-extended, so only the ALU op is chosen here
         OP_LUI:   begin o_alu_fun = ALU_SLL; o_sign = 1'b0; end
         OP_BEQ:   o_alu_fun = ALU_EQ;
         OP_BNE:   o_alu_fun = ALU_NEQ;
         OP_BLEZ:  o_alu_fun = ALU_LEZ;
         OP_BGTZ:  o_alu_fun = ALU_GTZ;
         OP_LW, OP_SW, OP_J, OP_JAL: o_alu_fun = ALU_ADD;
         default:  o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: one state per cycle, drives ALU function,
// operand selects and datapath write enables; memory states stall on MemReady.
module mc_control
   import mips_ctrl_pkg::*;
#(
   parameter bit EXC_EN = 1'b1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   OpCode,
   input  logic [FN_W-1:0]   Funct,
   input  logic              Cond,
   input  logic              MemReady,
   output logic [ALU_W-1:0]  ALUFun,
   output logic [SEL_W-1:0]  ALUSrcA,
   output logic [SEL_W-1:0]  ALUSrcB,
   output logic              Sign,
   output logic              PCWrite,
   output logic              PCWriteCond,
   output logic [SEL_W-1:0]  PCSource,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic [SEL_W-1:0]  RegDst,
   output logic              RegWrite,
   output logic [SEL_W-1:0]  MemtoReg,
   output logic              Illegal,
   output logic [STATE_W-1:0] State
);

   state_e             r_state;
   state_e             w_next;
   logic [ALU_W-1:0]   w_dec_fun;
   logic               w_dec_sign;
   logic               w_dec_illegal;
   logic               w_unused;

   // Branch gating by Cond happens in the datapath, not here
   assign w_unused = Cond;
   assign State    = r_state;

   mc_alu_fun_dec u_dec (
      .i_opcode  (OpCode),
      .i_funct   (Funct),
      .o_alu_fun (w_dec_fun),
      .o_sign    (w_dec_sign),
      .o_illegal (w_dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      ALUFun      = ALU_ADD;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RT;
      Sign        = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = PCSRC_ALU;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = REGDST_RT;
      RegWrite    = 1'b0;
      MemtoReg    = M2R_ALU;
      Illegal     = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCWrite = MemReady;
            if (MemReady) w_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH2;
            Sign    = 1'b1;
            case (OpCode)
               OP_RTYPE: w_next = ((Funct == FN_JR) || (Funct == FN_JALR)) ? S_JUMP : S_EXEC_R;
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_next = S_BRANCH;
               OP_J, OP_JAL: w_next = S_JUMP;
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
               OP_SLTI, OP_SLTIU, OP_LUI: w_next = S_EXEC_I;
               default: w_next = EXC_EN ? S_TRAP : S_FETCH;
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = is_shift(Funct) ? SRCA_SHAMT : SRCA_RS;
            ALUFun  = w_dec_fun;
            Sign    = w_dec_sign;
            if (w_dec_illegal) w_next = EXC_EN ? S_TRAP : S_FETCH;
            else               w_next = S_WB_ALU;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_RS;
            ALUSrcB = SRCB_IMM;
            ALUFun  = w_dec_fun;
            Sign    = w_dec_sign;
            w_next  = S_WB_ALU;
         end
         S_WB_ALU: begin
            RegWrite = 1'b1;
            RegDst   = (OpCode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            w_next   = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = SRCA_RS;
            ALUSrcB = SRCB_IMM;
            Sign    = 1'b1;
            w_next  = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (MemReady) w_next = S_WB_MEM;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) w_next = S_FETCH;
         end
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = M2R_MDR;
            w_next   = S_FETCH;
         end
         S_BRANCH: begin
            // blez/bgtz encode rt=$0, so the rt path supplies the zero operand
            ALUSrcA     = SRCA_RS;
            ALUFun      = w_dec_fun;
            Sign        = 1'b1;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            if (OpCode == OP_RTYPE) begin
               ALUSrcA  = SRCA_RS;
               ALUFun   = w_dec_fun;
               PCSource = PCSRC_ALU;
               if (Funct == FN_JALR) begin
                  RegWrite = 1'b1;
                  RegDst   = REGDST_RD;
                  MemtoReg = M2R_PC;
               end
            end else begin
               PCSource = PCSRC_JUMP;
               if (OpCode == OP_JAL) begin
                  RegWrite = 1'b1;
                  RegDst   = REGDST_RA;
                  MemtoReg = M2R_PC;
               end
            end
            w_next = S_FETCH;
         end
         S_TRAP: begin
            Illegal  = 1'b1;
            PCWrite  = 1'b1;
            PCSource = PCSRC_EXC;
            w_next   = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
      // Reset abandons any access in flight: no architectural write this cycle
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         MemRead     = 1'b0;
         Illegal     = 1'b0;
         ALUFun      = ALU_ADD;
         w_next      = S_FETCH;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction stream against a per-instruction state-sequence model;
// a second instance with exceptions disabled covers the illegal-as-NOP path.
module tb_mc_control;

   localparam int ST_F = 0, ST_D = 1, ST_EXR = 2, ST_EXI = 3, ST_MA = 4, ST_MR = 5;
   localparam int ST_MW = 6, ST_WBM = 7, ST_WBA = 8, ST_BR = 9, ST_JMP = 10, ST_TRP = 11;

   localparam int C_R = 0, C_SH = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5;
   localparam int C_J = 6, C_JAL = 7, C_JR = 8, C_JALR = 9, C_BADOP = 10, C_BADF = 11;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         cls;
      logic [5:0] alu;
      logic       sgn;
      string      name;
   } ins_t;

   logic       clk;
   logic       reset;
   logic [5:0] OpCode, Funct;
   logic       Cond, MemReady;

   logic [5:0] a_ALUFun, b_ALUFun;
   logic [1:0] a_ALUSrcA, a_ALUSrcB, a_PCSource, a_RegDst, a_MemtoReg;
   logic [1:0] b_ALUSrcA, b_ALUSrcB, b_PCSource, b_RegDst, b_MemtoReg;
   logic       a_Sign, a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite;
   logic       a_IRWrite, a_RegWrite, a_Illegal;
   logic       b_Sign, b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite;
   logic       b_IRWrite, b_RegWrite, b_Illegal;
   logic [3:0] a_State, b_State;

   int   n_tests = 0;
   int   n_fail  = 0;
   ins_t tbl[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mc_control #(.EXC_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Cond(Cond), .MemReady(MemReady),
      .ALUFun(a_ALUFun), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .Sign(a_Sign),
      .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCSource(a_PCSource), .IorD(a_IorD),
      .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegDst(a_RegDst),
      .RegWrite(a_RegWrite), .MemtoReg(a_MemtoReg), .Illegal(a_Illegal), .State(a_State)
   );

   mc_control #(.EXC_EN(1'b0)) dut_nx (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Cond(Cond), .MemReady(MemReady),
      .ALUFun(b_ALUFun), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .Sign(b_Sign),
      .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .PCSource(b_PCSource), .IorD(b_IorD),
      .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
      .RegWrite(b_RegWrite), .MemtoReg(b_MemtoReg), .Illegal(b_Illegal), .State(b_State)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void add_ins(input logic [5:0] op, input logic [5:0] fn, input int cls,
                                   input logic [5:0] alu, input logic sgn, input string name);
      ins_t e;
      e.op = op; e.fn = fn; e.cls = cls; e.alu = alu; e.sgn = sgn; e.name = name;
      tbl.push_back(e);
   endfunction

   function automatic int find(input string name);
      foreach (tbl[i]) if (tbl[i].name == name) return i;
      return 0;
   endfunction

   // One instruction: build the expected state trace, then walk it cycle by cycle
   task automatic run_ins(input int idx, input int fs, input int ms);
      ins_t e;
      int   q[$];
      int   s, rw_cnt, ill_cnt, rw_exp, ill_exp;
      logic stall;
      e = tbl[idx];
      rw_cnt = 0; ill_cnt = 0;
      OpCode = e.op;
      Funct  = (e.op == 6'h00) ? e.fn : 6'($urandom);
      for (int i = 0; i <= fs; i++) q.push_back(ST_F);
      q.push_back(ST_D);
      case (e.cls)
         C_R, C_SH: begin q.push_back(ST_EXR); q.push_back(ST_WBA); end
         C_I:       begin q.push_back(ST_EXI); q.push_back(ST_WBA); end
         C_LW: begin
            q.push_back(ST_MA);
            for (int i = 0; i <= ms; i++) q.push_back(ST_MR);
            q.push_back(ST_WBM);
         end
         C_SW: begin
            q.push_back(ST_MA);
            for (int i = 0; i <= ms; i++) q.push_back(ST_MW);
         end
         C_BR:    q.push_back(ST_BR);
         C_BADOP: q.push_back(ST_TRP);
         C_BADF:  begin q.push_back(ST_EXR); q.push_back(ST_TRP); end
         default: q.push_back(ST_JMP);
      endcase
      rw_exp  = (e.cls inside {C_R, C_SH, C_I, C_LW, C_JAL, C_JALR}) ? 1 : 0;
      ill_exp = (e.cls inside {C_BADOP, C_BADF}) ? 1 : 0;

      for (int k = 0; k < q.size(); k++) begin
         s     = q[k];
         stall = (k + 1 < q.size()) && (q[k+1] == s);
         if (s inside {ST_F, ST_MR, ST_MW}) MemReady = ~stall;
         else                               MemReady = 1'($urandom);
         Cond = 1'($urandom);
         #1;
         chk_eq($sformatf("%s.state%0d", e.name, k), a_State, s);
         if (a_RegWrite) rw_cnt++;
         if (a_Illegal)  ill_cnt++;
         case (s)
            ST_F: begin
               chk_eq("fetch.memread", a_MemRead, 1);
               chk_eq("fetch.srcb", a_ALUSrcB, 1);
               chk_eq("fetch.irwrite", a_IRWrite, MemReady);
               chk_eq("fetch.pcwrite", a_PCWrite, MemReady);
            end
            ST_D: begin
               chk_eq("decode.srcb", a_ALUSrcB, 3);
               chk_eq("decode.alufun", a_ALUFun, 0);
               chk_eq("decode.writes", {a_PCWrite, a_MemWrite, a_IRWrite}, 0);
            end
            ST_EXR: if (e.cls != C_BADF) begin
               chk_eq({e.name, ".alufun"}, a_ALUFun, e.alu);
               chk_eq({e.name, ".sign"}, a_Sign, e.sgn);
               chk_eq({e.name, ".srca"}, a_ALUSrcA, (e.cls == C_SH) ? 2 : 1);
               chk_eq({e.name, ".srcb"}, a_ALUSrcB, 0);
            end
            ST_EXI: begin
               chk_eq({e.name, ".alufun"}, a_ALUFun, e.alu);
               chk_eq({e.name, ".sign"}, a_Sign, e.sgn);
               chk_eq({e.name, ".srcb"}, a_ALUSrcB, 2);
            end
            ST_WBA: begin
               chk_eq({e.name, ".regdst"}, a_RegDst, (e.op == 6'h00) ? 1 : 0);
               chk_eq({e.name, ".memtoreg"}, a_MemtoReg, 0);
            end
            ST_MA: begin
               chk_eq("memaddr.srcb", a_ALUSrcB, 2);
               chk_eq("memaddr.sign", a_Sign, 1);
            end
            ST_MR: chk_eq("memrd.rd_iord", {a_MemRead, a_IorD}, 2'b11);
            ST_MW: chk_eq("memwr.wr_iord", {a_MemWrite, a_IorD}, 2'b11);
            ST_WBM: chk_eq("wbmem.m2r_dst", {a_MemtoReg, a_RegDst}, 4'b0100);
            ST_BR: begin
               chk_eq({e.name, ".alufun"}, a_ALUFun, e.alu);
               chk_eq({e.name, ".pcwc_src"}, {a_PCWriteCond, a_PCSource}, 3'b101);
            end
            ST_JMP: begin
               chk_eq({e.name, ".pcwrite"}, a_PCWrite, 1);
               if (e.cls inside {C_JR, C_JALR}) begin
                  chk_eq({e.name, ".pcsrc"}, a_PCSource, 0);
                  chk_eq({e.name, ".alufun"}, a_ALUFun, 6'b011010);
               end else begin
                  chk_eq({e.name, ".pcsrc"}, a_PCSource, 2);
               end
               if (e.cls == C_JAL)  chk_eq("jal.dst_m2r", {a_RegDst, a_MemtoReg}, 4'b1010);
               if (e.cls == C_JALR) chk_eq("jalr.dst_m2r", {a_RegDst, a_MemtoReg}, 4'b0110);
            end
            ST_TRP: chk_eq({e.name, ".trap"}, {a_Illegal, a_PCWrite, a_PCSource}, 4'b1111);
            default: ;
         endcase
         @(negedge clk);
      end
      chk_eq({e.name, ".regwrites"}, rw_cnt, rw_exp);
      chk_eq({e.name, ".illegals"}, ill_cnt, ill_exp);
   endtask

   initial begin
      int exp_a[3];
      int exp_b[3];
      add_ins(6'h00, 6'h20, C_R,  6'b000000, 1'b1, "add");
      add_ins(6'h00, 6'h21, C_R,  6'b000000, 1'b0, "addu");
      add_ins(6'h00, 6'h22, C_R,  6'b000001, 1'b1, "sub");
      add_ins(6'h00, 6'h23, C_R,  6'b000001, 1'b0, "subu");
      add_ins(6'h00, 6'h24, C_R,  6'b011000, 1'b1, "and");
      add_ins(6'h00, 6'h25, C_R,  6'b011110, 1'b1, "or");
      add_ins(6'h00, 6'h26, C_R,  6'b010110, 1'b1, "xor");
      add_ins(6'h00, 6'h27, C_R,  6'b010001, 1'b1, "nor");
      add_ins(6'h00, 6'h2A, C_R,  6'b110101, 1'b1, "slt");
      add_ins(6'h00, 6'h2B, C_R,  6'b110101, 1'b0, "sltu");
      add_ins(6'h00, 6'h00, C_SH, 6'b100000, 1'b1, "sll");
      add_ins(6'h00, 6'h02, C_SH, 6'b100001, 1'b1, "srl");
      add_ins(6'h00, 6'h03, C_SH, 6'b100011, 1'b1, "sra");
      add_ins(6'h00, 6'h08, C_JR,   6'b011010, 1'b1, "jr");
      add_ins(6'h00, 6'h09, C_JALR, 6'b011010, 1'b1, "jalr");
      add_ins(6'h00, 6'h3F, C_BADF, 6'b000000, 1'b1, "badfn3f");
      add_ins(6'h00, 6'h01, C_BADF, 6'b000000, 1'b1, "badfn01");
      add_ins(6'h08, 6'h00, C_I,  6'b000000, 1'b1, "addi");
      add_ins(6'h09, 6'h00, C_I,  6'b000000, 1'b1, "addiu");
      add_ins(6'h0A, 6'h00, C_I,  6'b110101, 1'b1, "slti");
      add_ins(6'h0B, 6'h00, C_I,  6'b110101, 1'b0, "sltiu");
      add_ins(6'h0C, 6'h00, C_I,  6'b011000, 1'b0, "andi");
      add_ins(6'h0D, 6'h00, C_I,  6'b011110, 1'b0, "ori");
      add_ins(6'h0E, 6'h00, C_I,  6'b010110, 1'b0, "xori");
      add_ins(6'h0F, 6'h00, C_I,  6'b100000, 1'b0, "lui");
      add_ins(6'h23, 6'h00, C_LW, 6'b000000, 1'b1, "lw");
      add_ins(6'h2B, 6'h00, C_SW, 6'b000000, 1'b1, "sw");
      add_ins(6'h04, 6'h00, C_BR, 6'b110011, 1'b1, "beq");
      add_ins(6'h05, 6'h00, C_BR, 6'b110001, 1'b1, "bne");
      add_ins(6'h06, 6'h00, C_BR, 6'b111101, 1'b1, "blez");
      add_ins(6'h07, 6'h00, C_BR, 6'b111111, 1'b1, "bgtz");
      add_ins(6'h02, 6'h00, C_J,   6'b000000, 1'b1, "j");
      add_ins(6'h03, 6'h00, C_JAL, 6'b000000, 1'b1, "jal");
      add_ins(6'h3F, 6'h00, C_BADOP, 6'b000000, 1'b1, "badop3f");
      add_ins(6'h10, 6'h00, C_BADOP, 6'b000000, 1'b1, "badop10");
      add_ins(6'h01, 6'h00, C_BADOP, 6'b000000, 1'b1, "badop01");

      // Reset held with MemReady high: FETCH must not strobe any write
      reset = 1'b1; MemReady = 1'b1; Cond = 1'b0; OpCode = 6'h00; Funct = 6'h20;
      @(negedge clk);
      #1;
      chk_eq("rst.state", a_State, 0);
      chk_eq("rst.writes", {a_PCWrite, a_PCWriteCond, a_IRWrite, a_RegWrite, a_MemWrite}, 0);
      chk_eq("rst.memread", a_MemRead, 0);
      chk_eq("rst.illegal", a_Illegal, 0);
      chk_eq("rst.alufun", a_ALUFun, 0);
      reset = 1'b0;

      run_ins(find("add"), 0, 0);
      run_ins(find("lw"), 0, 3);
      run_ins(find("beq"), 0, 0);
      run_ins(find("bne"), 0, 0);
      run_ins(find("jal"), 0, 0);
      run_ins(find("badop3f"), 0, 0);
      run_ins(find("sw"), 2, 2);

      // Reset arriving during a MEM_WR stall
      OpCode = 6'h2B; Funct = 6'h00; MemReady = 1'b1;
      @(negedge clk);
      MemReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_eq("rstwr.pre_state", a_State, 6);
      chk_eq("rstwr.pre_memwrite", a_MemWrite, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_eq("rstwr.state", a_State, 6);
      chk_eq("rstwr.writes", {a_MemWrite, a_PCWrite, a_IRWrite, a_RegWrite}, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_eq("rstwr.next_state", a_State, 0);
      chk_eq("rstwr.next_writes", {a_IRWrite, a_PCWrite}, 0);
      @(negedge clk);

      for (int n = 0; n < 200; n++)
         run_ins($urandom_range(0, tbl.size() - 1), $urandom_range(0, 3), $urandom_range(0, 3));

      // Illegal opcode with and without exceptions enabled
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; OpCode = 6'h3F; Funct = 6'h00; MemReady = 1'b1;
      exp_a = '{0, 1, 11};
      exp_b = '{0, 1, 0};
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_eq($sformatf("exc1.state%0d", c), a_State, exp_a[c]);
         chk_eq($sformatf("exc1.illegal%0d", c), a_Illegal, (c == 2) ? 1 : 0);
         chk_eq($sformatf("exc0.state%0d", c), b_State, exp_b[c]);
         chk_eq($sformatf("exc0.illegal%0d", c), b_Illegal, 0);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
